// File: rtl/hazard_ctrl.sv
// hazard_ctrl: E/M/W control pipeline, load-use/RAW hazard detection, operand forwarding and stall counting; optional macro HAZARD_FWD_EN enables forwarding
module hazard_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWriteD,
    input  logic        MemWriteD,
    input  logic        JumpD,
    input  logic        BranchD,
    input  logic        ALUSrcD,
    input  logic [1:0]  ResultSrcD,
    input  logic [2:0]  ALUControlD,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  RdD,
    input  logic        ZeroE,
    output logic [2:0]  ALUControlE,
    output logic        ALUSrcE,
    output logic [4:0]  Rs1E,
    output logic [4:0]  Rs2E,
    output logic [4:0]  RdE,
    output logic        MemWriteM,
    output logic [4:0]  RdM,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [4:0]  RdW,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushD,
    output logic        FlushE,
    output logic        PCSrcE,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic [15:0] StallCount
);
    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic       alu_src;
        logic [1:0] result_src;
        logic [2:0] alu_ctrl;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } stage_t;

    stage_t      e_q, e_d;
    logic        m_regw_q, m_memw_q, w_regw_q;
    logic [1:0]  m_rsrc_q, w_rsrc_q;
    logic [4:0]  m_rd_q, w_rd_q;
    logic [15:0] cnt_q, cnt_d;
    logic        hazard;

    // x0 is hardwired zero, so a match on it is never a real dependency
    function automatic logic hit(input logic [4:0] rs, input logic we, input logic [4:0] rd);
        return rs != 5'd0 && we && rs == rd;
    endfunction

`ifdef HAZARD_FWD_EN
    logic lw_stall;
    // only a load in Execute cannot be forwarded in time
    always_comb lw_stall = e_q.result_src == 2'b01 && (hit(Rs1D, 1'b1, e_q.rd) || hit(Rs2D, 1'b1, e_q.rd));
    // hazard source: load-use only
    always_comb hazard = lw_stall;
    // operand A select, Memory producer is younger and wins over Writeback
    always_comb ForwardAE = hit(e_q.rs1, m_regw_q, m_rd_q) ? 2'b10 : hit(e_q.rs1, w_regw_q, w_rd_q) ? 2'b01 : 2'b00;
    // operand B select, same priority as A
    always_comb ForwardBE = hit(e_q.rs2, m_regw_q, m_rd_q) ? 2'b10 : hit(e_q.rs2, w_regw_q, w_rd_q) ? 2'b01 : 2'b00;
`else
    // without forwarding any in-flight writer in E or M must drain first; W writes the register file early enough
    always_comb hazard = hit(Rs1D, e_q.reg_write, e_q.rd) || hit(Rs1D, m_regw_q, m_rd_q)
                      || hit(Rs2D, e_q.reg_write, e_q.rd) || hit(Rs2D, m_regw_q, m_rd_q);
    // operands always come from the register file
    always_comb {ForwardAE, ForwardBE} = 4'b0000;
`endif

    // redirect in Execute squashes D and E, and overrides any stall
    always_comb begin
        PCSrcE = (e_q.branch & ZeroE) | e_q.jump;
        StallD = hazard & ~PCSrcE;
        StallF = StallD;
        FlushD = PCSrcE;
        FlushE = PCSrcE | StallD;
    end

    // Execute loads a bubble on flush; a stall holds only the upstream registers
    always_comb e_d = FlushE ? '0 : {RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ResultSrcD, ALUControlD, Rs1D, Rs2D, RdD};

    // stall counter saturates instead of wrapping
    always_comb cnt_d = (StallD && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;

    // pipeline advance; reset discards everything in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            e_q      <= '0;
            m_regw_q <= 1'b0;
            m_memw_q <= 1'b0;
            m_rsrc_q <= 2'b00;
            m_rd_q   <= 5'd0;
            w_regw_q <= 1'b0;
            w_rsrc_q <= 2'b00;
            w_rd_q   <= 5'd0;
            cnt_q    <= 16'd0;
        end else begin
            e_q      <= e_d;
            m_regw_q <= e_q.reg_write;
            m_memw_q <= e_q.mem_write;
            m_rsrc_q <= e_q.result_src;
            m_rd_q   <= e_q.rd;
            w_regw_q <= m_regw_q;
            w_rsrc_q <= m_rsrc_q;
            w_rd_q   <= m_rd_q;
            cnt_q    <= cnt_d;
        end
    end

    // stage register outputs
    always_comb begin
        ALUControlE = e_q.alu_ctrl;
        ALUSrcE     = e_q.alu_src;
        Rs1E        = e_q.rs1;
        Rs2E        = e_q.rs2;
        RdE         = e_q.rd;
        MemWriteM   = m_memw_q;
        RdM         = m_rd_q;
        RegWriteW   = w_regw_q;
        ResultSrcW  = w_rsrc_q;
        RdW         = w_rd_q;
        StallCount  = cnt_q;
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven pipeline vectors plus directed load-use, forwarding, reset and saturation sequences
module tb_hazard_ctrl;
    logic        clk, reset;
    logic        RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ZeroE;
    logic [1:0]  ResultSrcD;
    logic [2:0]  ALUControlD;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic [2:0]  ALUControlE;
    logic        ALUSrcE, MemWriteM, RegWriteW, StallF, StallD, FlushD, FlushE, PCSrcE;
    logic [4:0]  Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]  ResultSrcW, ForwardAE, ForwardBE;
    logic [15:0] StallCount;
    logic [57:0] all_o;
    int          n_vec = 0;
    int          n_err = 0;

    hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD), .ALUSrcD(ALUSrcD),
        .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ZeroE(ZeroE),
        .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .MemWriteM(MemWriteM), .RdM(RdM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE), .PCSrcE(PCSrcE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallCount(StallCount)
    );

    assign all_o = {ALUControlE, ALUSrcE, Rs1E, Rs2E, RdE, MemWriteM, RdM, RegWriteW, ResultSrcW, RdW,
                    StallF, StallD, FlushD, FlushE, PCSrcE, ForwardAE, ForwardBE, StallCount};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rw, mw, jp, br;
        logic [1:0] rs;
        logic [4:0] a, b, d;
        logic       z;
        logic       st_nf, st_fw, pc;
        logic [1:0] fa;
        logic [4:0] rde_nf, rde_fw;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_d(input logic rw, mw, jp, br, as, input logic [1:0] rs, input logic [2:0] ac,
                         input logic [4:0] a, b, d, input logic z);
        RegWriteD = rw; MemWriteD = mw; JumpD = jp; BranchD = br; ALUSrcD = as;
        ResultSrcD = rs; ALUControlD = ac; Rs1D = a; Rs2D = b; RdD = d; ZeroE = z;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_d(0, 0, 0, 0, 0, 2'b00, 3'd0, 5'd0, 5'd0, 5'd0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        logic       st;
        logic [1:0] fa;
        logic [4:0] rde;
        //            rw mw jp br rs  a  b  d  z  nf fw pc fa rde_nf rde_fw
        tbl[0]  = '{1, 0, 0, 0, 0,  1, 2, 3, 0, 0, 0, 0, 0,  0,  0};
        tbl[1]  = '{1, 0, 0, 0, 0,  3, 0, 4, 0, 1, 0, 0, 0,  3,  3};
        tbl[2]  = '{1, 0, 0, 0, 0,  3, 0, 4, 0, 1, 0, 0, 2,  0,  4};
        tbl[3]  = '{1, 0, 0, 0, 0,  3, 0, 4, 0, 0, 0, 0, 1,  0,  4};
        tbl[4]  = '{1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0,  4,  4};
        tbl[5]  = '{0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0,  0,  0};
        tbl[6]  = '{1, 0, 0, 0, 0,  8, 8, 9, 1, 0, 0, 1, 0,  0,  0};
        tbl[7]  = '{1, 0, 0, 0, 0, 11,12,10, 0, 0, 0, 0, 0,  0,  0};
        tbl[8]  = '{1, 0, 1, 0, 2,  0, 0, 1, 0, 0, 0, 0, 0, 10, 10};
        tbl[9]  = '{1, 0, 0, 0, 0,  1, 0, 2, 0, 0, 0, 1, 0,  1,  1};
        tbl[10] = '{1, 0, 0, 0, 0,  1, 0, 2, 0, 1, 0, 0, 0,  0,  0};
        tbl[11] = '{1, 0, 0, 0, 0,  1, 0, 2, 0, 0, 0, 0, 1,  0,  2};
        tbl[12] = '{0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0,  2,  2};
        tbl[13] = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0,  0,  0};

        // reset state
        do_reset();
        chk("reset_outs", 64'(all_o), 64'd0);

        // table pipeline run
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            set_d(tbl[i].rw, tbl[i].mw, tbl[i].jp, tbl[i].br, 0, tbl[i].rs, 3'd0, tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].z);
            #1;
`ifdef HAZARD_FWD_EN
            st = tbl[i].st_fw; fa = tbl[i].fa; rde = tbl[i].rde_fw;
`else
            st = tbl[i].st_nf; fa = 2'b00; rde = tbl[i].rde_nf;
`endif
            chk($sformatf("v%0d_StallF", i), 64'(StallF), 64'(st));
            chk($sformatf("v%0d_StallD", i), 64'(StallD), 64'(st));
            chk($sformatf("v%0d_PCSrcE", i), 64'(PCSrcE), 64'(tbl[i].pc));
            chk($sformatf("v%0d_FlushD", i), 64'(FlushD), 64'(tbl[i].pc));
            chk($sformatf("v%0d_FlushE", i), 64'(FlushE), 64'(tbl[i].pc | st));
            chk($sformatf("v%0d_FwdA", i), 64'(ForwardAE), 64'(fa));
            chk($sformatf("v%0d_FwdB", i), 64'(ForwardBE), 64'd0);
            chk($sformatf("v%0d_RdE", i), 64'(RdE), 64'(rde));
            if (i == 9) chk("flushed_in_W", 64'({RegWriteW, RdW}), 64'd0);
        end

        // stage pass-through of control fields
        do_reset();
        @(negedge clk); set_d(1, 1, 0, 0, 1, 2'b01, 3'b101, 5'd10, 5'd11, 5'd12, 0); #1;
        @(negedge clk); set_d(0, 0, 0, 0, 0, 2'b00, 3'd0, 5'd0, 5'd0, 5'd0, 0); #1;
        chk("pass_E", 64'({ALUControlE, ALUSrcE, Rs1E, Rs2E, RdE}), 64'({3'b101, 1'b1, 5'd10, 5'd11, 5'd12}));
        @(negedge clk); #1;
        chk("pass_M", 64'({MemWriteM, RdM}), 64'({1'b1, 5'd12}));
        @(negedge clk); #1;
        chk("pass_W", 64'({RegWriteW, ResultSrcW, RdW}), 64'({1'b1, 2'b01, 5'd12}));

        // load-use: lw x5 then add x6,x5,x7
        do_reset();
        @(negedge clk); set_d(1, 0, 0, 0, 0, 2'b01, 3'd0, 5'd0, 5'd0, 5'd5, 0); #1;
        @(negedge clk); set_d(1, 0, 0, 0, 0, 2'b00, 3'd0, 5'd5, 5'd7, 5'd6, 0); #1;
        chk("lu_stall", 64'({StallF, StallD, FlushE, FlushD}), 64'(4'b1110));
        chk("lu_cnt0", 64'(StallCount), 64'd0);
        @(negedge clk); #1;
        chk("lu_cnt1", 64'(StallCount), 64'd1);
`ifdef HAZARD_FWD_EN
        chk("lu_release", 64'(StallD), 64'd0);
        @(negedge clk); #1;
        chk("lu_fwdA", 64'(ForwardAE), 64'd1);
        chk("lu_RdE", 64'(RdE), 64'd6);
        chk("lu_cnt_hold", 64'(StallCount), 64'd1);
`else
        chk("lu_Mstall", 64'(StallD), 64'd1);
        @(negedge clk); #1;
        chk("lu_release", 64'(StallD), 64'd0);
        chk("lu_cnt2", 64'(StallCount), 64'd2);
        @(negedge clk); #1;
        chk("lu_RdE", 64'(RdE), 64'd6);
        chk("lu_fwdA", 64'(ForwardAE), 64'd0);
`endif
        // reset asserted during a stall cycle
        @(negedge clk); set_d(1, 0, 0, 0, 0, 2'b01, 3'd0, 5'd0, 5'd0, 5'd5, 0); #1;
        @(negedge clk); set_d(1, 0, 0, 0, 0, 2'b00, 3'd0, 5'd5, 5'd7, 5'd6, 0); #1;
        chk("rst_pre_stall", 64'(StallD), 64'd1);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0; set_d(0, 0, 0, 0, 0, 2'b00, 3'd0, 5'd0, 5'd0, 5'd0, 0); #1;
        chk("rst_mid_outs", 64'(all_o), 64'd0);

        // forwarding priority M over W, then W only, then x0
        do_reset();
        @(negedge clk); set_d(1, 0, 0, 0, 0, 2'b00, 3'd0, 5'd1, 5'd2, 5'd3, 0); #1;
        @(negedge clk); set_d(1, 0, 0, 0, 0, 2'b00, 3'd0, 5'd1, 5'd2, 5'd3, 0); #1;
        @(negedge clk); set_d(1, 0, 0, 0, 0, 2'b00, 3'd0, 5'd3, 5'd3, 5'd7, 0); #1;
        @(negedge clk); set_d(1, 0, 0, 0, 0, 2'b00, 3'd0, 5'd3, 5'd0, 5'd8, 0); #1;
`ifdef HAZARD_FWD_EN
        chk("fp_MW", 64'({ForwardAE, ForwardBE}), 64'(4'b1010));
`else
        chk("fp_MW", 64'({ForwardAE, ForwardBE}), 64'd0);
`endif
        @(negedge clk); set_d(1, 0, 0, 0, 0, 2'b00, 3'd0, 5'd0, 5'd0, 5'd0, 0); #1;
`ifdef HAZARD_FWD_EN
        chk("fp_W", 64'({ForwardAE, ForwardBE}), 64'(4'b0100));
`else
        chk("fp_W", 64'({ForwardAE, ForwardBE}), 64'd0);
`endif
        @(negedge clk); set_d(1, 0, 0, 0, 0, 2'b00, 3'd0, 5'd0, 5'd0, 5'd9, 0); #1;
        @(negedge clk); set_d(0, 0, 0, 0, 0, 2'b00, 3'd0, 5'd0, 5'd0, 5'd0, 0); #1;
        chk("fp_x0", 64'({ForwardAE, ForwardBE}), 64'd0);

        // saturation of the stall counter
        do_reset();
        force dut.hazard = 1'b1;
        repeat (65534) @(negedge clk);
        #1;
        chk("sat_stallD", 64'(StallD), 64'd1);
        chk("sat_fffe", 64'(StallCount), 64'hFFFE);
        @(negedge clk); #1;
        chk("sat_ffff", 64'(StallCount), 64'hFFFF);
        repeat (10) @(negedge clk);
        #1;
        chk("sat_hold", 64'(StallCount), 64'hFFFF);
        release dut.hazard;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
